wb_rr_arbiter: RTL
==================

// Module: wb_rr_arbiter
// PURPOSE
//  N-master round-robin arbiter that shares one wishbone slave (the L2 cache
//  port, or the L2-to-pmem port) among the cache-level masters. Grant is
//  registered and locked for a whole transaction. A one-cycle release state
//  absorbs the served master's trailing STB. A watchdog aborts hung transfers.
// PARAMETERS
//  N_MASTERS  2    number of requesters, >=2; index 0 wins ties after reset
//  ADDR_W     12   wishbone ADR width
//  SEL_W      16   wishbone SEL width
//  DATA_W     128  wishbone DAT_M/DAT_S width
//  TIMEOUT    64   BUSY cycles without s_ack before abort; 0 disables watchdog
// PORTS
//  CLK        in   1              clock, all state on rising edge
//  RST_N      in   1              async active-low reset
//  m_cyc      in   N              per-master CYC
//  m_stb      in   N              per-master STB (request)
//  m_we       in   N              per-master WE
//  m_adr      in   N x ADDR_W     per-master ADR
//  m_sel      in   N x SEL_W      per-master SEL
//  m_dat_m    in   N x DATA_W     per-master write data
//  m_dat_s    out  DATA_W         read data, broadcast = s_dat_s
//  m_ack      out  N              per-master ACK
//  m_rty      out  N              per-master RTY = ~(m_ack[i] & m_stb[i])
//  m_err      out  N              one-cycle pulse: watchdog abort of master i
//  s_cyc/s_stb/s_we out 1         slave CYC/STB/WE
//  s_adr      out  ADDR_W         slave ADR
//  s_sel      out  SEL_W          slave SEL
//  s_dat_m    out  DATA_W         slave write data
//  s_dat_s    in   DATA_W         slave read data
//  s_ack      in   1              slave ACK
// BEHAVIOUR
//  Reset: state=IDLE, grant=0, rr_ptr=0, wd_cnt=0. All 1-bit outputs 0;
//   s_adr/s_sel/s_dat_m='0. Reset applies asynchronously mid-transfer.
//  States: IDLE, BUSY, RELEASE (enum arb_state_t).
//  Pick: first i with m_stb[i]=1, scanning rr_ptr, rr_ptr+1, ... mod N.
//  IDLE: any m_stb -> grant<=pick, wd_cnt<=0, BUSY. Else stay.
//   Latency: STB seen at edge t -> s_stb=1 in cycle t+1.
//  BUSY: s_* = granted master's signals, muxed from registered grant.
//   m_ack[grant]=s_ack (combinational, same cycle); other m_ack=0.
//   s_ack=1 -> rr_ptr<=(grant+1) mod N, RELEASE.
//   m_stb[grant]=0 with s_ack=0 (abort) -> rr_ptr<=grant+1, IDLE, no ack.
//   s_ack=1 and abort in same cycle -> ack wins.
//   wd_cnt==TIMEOUT-1 and s_ack=0 -> m_err[grant]=1 this cycle,
//   rr_ptr<=grant+1, RELEASE.
//  RELEASE: s_cyc=s_stb=0, no m_ack. The previous grantee's m_stb is masked.
//   Pick among the remaining requesters -> BUSY directly, with no IDLE bubble.
//   No remaining requester -> IDLE.
//  s_ack outside BUSY is ignored; no m_ack, no state change.
//  rr_ptr wraps N-1 -> 0. wd_cnt width $clog2(TIMEOUT+1) and saturates.
//  A single persistent requester is served every 3rd cycle after its ack
//   (BUSY, RELEASE, IDLE).
// STRUCTURE
//  lc3b_types: add arb_state_t, lc3b_wb_adr/sel/data typedefs, ARB_TIMEOUT.
//  Sub-module rr_priority_pick: combinational rotate-and-encode.
//   Inputs: req[N], ptr, mask[N]. Outputs: valid, idx.
//   Used in both IDLE and RELEASE.
// TESTING
//  1 m_stb[0]=1 @c1, ADR 0x123, SEL 0xFFFF -> s_stb=1, s_adr=0x123 @c2;
//    s_ack @c4 -> m_ack[0]=1, m_rty[0]=0 @c4; s_stb=0 @c5.
//  2 m_stb=2'b11 from reset -> master 0 is served first; m_ack[0] is followed
//    by RELEASE, then s_adr=m_adr[1] on the next cycle.
//  3 Both masters request continuously for 6 transactions -> grant order
//    0,1,0,1,0,1; m_ack never goes to a non-granted master.
//  4 TIMEOUT=8, no s_ack -> m_err[g]=1 on the 8th BUSY cycle;
//    s_cyc=0 on the next cycle; the other master is granted if it requests.
//  5 Master 1 drops STB in its 3rd BUSY cycle -> s_stb=0 next cycle,
//    m_ack[1] never asserted, rr_ptr=0.
//  6 RST_N=0 mid-BUSY, between clock edges -> s_cyc/s_stb/m_ack=0 immediately;
//    after release, a tie goes to master 0.

Source files
------------

// File: rtl/wb_rr_arbiter_pkg.sv
// Shared types and defaults for the wishbone round-robin arbiter.
package wb_rr_arbiter_pkg;

  localparam int unsigned ARB_N_MASTERS = 2;
  localparam int unsigned ARB_ADDR_W    = 12;
  localparam int unsigned ARB_SEL_W     = 16;
  localparam int unsigned ARB_DATA_W    = 128;
  localparam int unsigned ARB_TIMEOUT   = 64;

  typedef logic [ARB_ADDR_W-1:0] wb_adr_t;
  typedef logic [ARB_SEL_W-1:0]  wb_sel_t;
  typedef logic [ARB_DATA_W-1:0] wb_data_t;

  typedef logic [1:0] arb_state_t;
  localparam arb_state_t ST_IDLE    = 2'd0;
  localparam arb_state_t ST_BUSY    = 2'd1;
  localparam arb_state_t ST_RELEASE = 2'd2;

endpackage

// File: rtl/wb_rr_arbiter_if.sv
// Wishbone bundle between N masters, the arbiter and one shared slave.
interface wb_rr_arbiter_if
  import wb_rr_arbiter_pkg::*;
#(
  parameter int unsigned N_MASTERS = ARB_N_MASTERS,
  parameter int unsigned ADDR_W    = ARB_ADDR_W,
  parameter int unsigned SEL_W     = ARB_SEL_W,
  parameter int unsigned DATA_W    = ARB_DATA_W
);

  logic [N_MASTERS-1:0]             m_cyc;
  logic [N_MASTERS-1:0]             m_stb;
  logic [N_MASTERS-1:0]             m_we;
  logic [N_MASTERS-1:0][ADDR_W-1:0] m_adr;
  logic [N_MASTERS-1:0][SEL_W-1:0]  m_sel;
  logic [N_MASTERS-1:0][DATA_W-1:0] m_dat_m;
  logic [DATA_W-1:0]                m_dat_s;
  logic [N_MASTERS-1:0]             m_ack;
  logic [N_MASTERS-1:0]             m_rty;
  logic [N_MASTERS-1:0]             m_err;

  logic              s_cyc;
  logic              s_stb;
  logic              s_we;
  logic [ADDR_W-1:0] s_adr;
  logic [SEL_W-1:0]  s_sel;
  logic [DATA_W-1:0] s_dat_m;
  logic [DATA_W-1:0] s_dat_s;
  logic              s_ack;

  // Arbiter view: takes master requests, drives the shared slave.
  modport arb (
    input  m_cyc, m_stb, m_we, m_adr, m_sel, m_dat_m, s_dat_s, s_ack,
    output m_dat_s, m_ack, m_rty, m_err,
    output s_cyc, s_stb, s_we, s_adr, s_sel, s_dat_m
  );

  modport master (
    output m_cyc, m_stb, m_we, m_adr, m_sel, m_dat_m,
    input  m_dat_s, m_ack, m_rty, m_err
  );

  modport slave (
    input  s_cyc, s_stb, s_we, s_adr, s_sel, s_dat_m,
    output s_dat_s, s_ack
  );

endinterface

// File: rtl/wb_rr_arbiter_pick.sv
// Rotating priority pick: first unmasked requester at or after ptr, mod N.
module wb_rr_arbiter_pick #(
  parameter int unsigned N_MASTERS = 2
) (
  input  logic [N_MASTERS-1:0]         req,
  input  logic [$clog2(N_MASTERS)-1:0] ptr,
  input  logic [N_MASTERS-1:0]         mask,
  output logic                         valid_c,
  output logic [$clog2(N_MASTERS)-1:0] idx_c
);

  localparam int unsigned PTR_W = $clog2(N_MASTERS);

  logic [N_MASTERS-1:0] eff;
  logic [PTR_W:0]       slot;

  always_comb begin
    eff     = req & ~mask;
    valid_c = 1'b0;
    idx_c   = '0;
    slot    = '0;
    for (int unsigned k = 0; k < N_MASTERS; k++) begin
      slot = {1'b0, ptr} + (PTR_W+1)'(k);
      if (slot >= (PTR_W+1)'(N_MASTERS)) slot = slot - (PTR_W+1)'(N_MASTERS);
      if (!valid_c && eff[slot[PTR_W-1:0]]) begin
        valid_c = 1'b1;
        idx_c   = slot[PTR_W-1:0];
      end
    end
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter sharing one wishbone slave among N masters, with a
// locked grant per transaction, a one-cycle release state and a watchdog.
module wb_rr_arbiter
  import wb_rr_arbiter_pkg::*;
#(
  parameter int unsigned N_MASTERS = ARB_N_MASTERS,
  parameter int unsigned ADDR_W    = ARB_ADDR_W,
  parameter int unsigned SEL_W     = ARB_SEL_W,
  parameter int unsigned DATA_W    = ARB_DATA_W,
  parameter int unsigned TIMEOUT   = ARB_TIMEOUT
) (
  input logic           clk,
  input logic           rst_n,
  wb_rr_arbiter_if.arb  bus
);

  localparam int unsigned PTR_W = $clog2(N_MASTERS);
  localparam int unsigned WD_W  = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

  arb_state_t       state_q, state_d;
  logic [PTR_W-1:0] grant_q, grant_d;
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [WD_W-1:0]  wd_cnt_q, wd_cnt_d;

  logic [PTR_W-1:0]     grant_inc;
  logic [N_MASTERS-1:0] pick_mask;
  logic                 pick_valid;
  logic [PTR_W-1:0]     pick_idx;
  logic                 wd_expire;

  assign grant_inc = (grant_q == PTR_W'(N_MASTERS - 1)) ? '0 : grant_q + PTR_W'(1);
  // The master just served is hidden while RELEASE absorbs its trailing STB.
  assign pick_mask = (state_q == ST_RELEASE) ? (N_MASTERS'(1) << grant_q) : '0;
  assign wd_expire = (TIMEOUT != 0) && (wd_cnt_q == WD_W'(TIMEOUT - 1));

  wb_rr_arbiter_pick #(.N_MASTERS(N_MASTERS)) u_pick (
    .req     (bus.m_stb),
    .ptr     (rr_ptr_q),
    .mask    (pick_mask),
    .valid_c (pick_valid),
    .idx_c   (pick_idx)
  );

  assign bus.m_dat_s = bus.s_dat_s;
  assign bus.m_rty   = ~(bus.m_ack & bus.m_stb);

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    wd_cnt_d    = wd_cnt_q;
    bus.s_cyc   = 1'b0;
    bus.s_stb   = 1'b0;
    bus.s_we    = 1'b0;
    bus.s_adr   = '0;
    bus.s_sel   = '0;
    bus.s_dat_m = '0;
    bus.m_ack   = '0;
    bus.m_err   = '0;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_d  = pick_idx;
          wd_cnt_d = '0;
          state_d  = ST_BUSY;
        end
      end
      ST_BUSY: begin
        bus.s_cyc          = bus.m_cyc[grant_q];
        bus.s_stb          = bus.m_stb[grant_q];
        bus.s_we           = bus.m_we[grant_q];
        bus.s_adr          = bus.m_adr[grant_q];
        bus.s_sel          = bus.m_sel[grant_q];
        bus.s_dat_m        = bus.m_dat_m[grant_q];
        bus.m_ack[grant_q] = bus.s_ack;
        // Ack beats a same-cycle STB drop; a dropped STB beats the watchdog.
        if (bus.s_ack) begin
          rr_ptr_d = grant_inc;
          state_d  = ST_RELEASE;
        end else if (!bus.m_stb[grant_q]) begin
          rr_ptr_d = grant_inc;
          state_d  = ST_IDLE;
        end else if (wd_expire) begin
          bus.m_err[grant_q] = 1'b1;
          rr_ptr_d           = grant_inc;
          state_d            = ST_RELEASE;
        end else if (wd_cnt_q != {WD_W{1'b1}}) begin
          wd_cnt_d = wd_cnt_q + WD_W'(1);
        end
      end
      ST_RELEASE: begin
        if (pick_valid) begin
          grant_d  = pick_idx;
          wd_cnt_d = '0;
          state_d  = ST_BUSY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      wd_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      wd_cnt_q <= wd_cnt_d;
    end
  end

endmodule
